// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding and SPI mode constants.
package spi_pkg;

    typedef logic [2:0] spi_state_t;

    localparam spi_state_t ST_IDLE   = 3'd0;
    localparam spi_state_t ST_SETUP  = 3'd1;
    localparam spi_state_t ST_SCK_LO = 3'd2;
    localparam spi_state_t ST_SCK_HI = 3'd3;
    localparam spi_state_t ST_HOLD   = 3'd4;

    // Mode 0 only: clock idles low, data sampled on the rising edge.
    localparam logic [1:0] SPI_MODE = 2'd0;
    localparam logic       SPI_CPOL = SPI_MODE[1];

endpackage

// File: rtl/spi_master.sv
// Byte-oriented SPI master (mode 0) with multi-byte frames held open by tx_last=0.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a byte; ss_n stays low inside an open frame
// SETUP     | ss_n just asserted, first bit on mosi, one half-period
// SCK_LO    | sck low half-period, current bit on mosi
// SCK_HI    | sck high half-period, miso captured on entry
// HOLD      | ss_n held low one half-period after the final byte
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       en,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       sck,
    output logic       ss_n,
    output logic       mosi,
    input  logic       miso
);

    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

    spi_state_t state;
    logic [7:0] cnt;
    logic [2:0] bit_cnt;
    logic [6:0] tx_sr;
    logic [7:0] rx_sr;
    logic       last_q;

    assign tx_ready = (state == ST_IDLE) && en;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state    <= ST_IDLE;
            cnt      <= 8'd0;
            bit_cnt  <= 3'd0;
            tx_sr    <= 7'd0;
            rx_sr    <= 8'd0;
            last_q   <= 1'b0;
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
            sck      <= SPI_CPOL;
            ss_n     <= 1'b1;
            mosi     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        tx_sr   <= tx_data[6:0];
                        mosi    <= tx_data[7];
                        last_q  <= tx_last;
                        bit_cnt <= 3'd7;
                        cnt     <= DIV_M1;
                        ss_n    <= 1'b0;
                        // An open frame skips the select setup time.
                        state   <= ss_n ? ST_SETUP : ST_SCK_LO;
                    end
                end
                ST_SETUP, ST_SCK_LO: begin
                    if (cnt == 8'd0) begin
                        state <= ST_SCK_HI;
                        sck   <= ~SPI_CPOL;
                        rx_sr <= {rx_sr[6:0], miso};
                        cnt   <= DIV_M1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_SCK_HI: begin
                    if (cnt == 8'd0) begin
                        sck <= SPI_CPOL;
                        cnt <= DIV_M1;
                        if (bit_cnt != 3'd0) begin
                            bit_cnt <= bit_cnt - 3'd1;
                            mosi    <= tx_sr[6];
                            tx_sr   <= {tx_sr[5:0], 1'b0};
                            state   <= ST_SCK_LO;
                        end else begin
                            rx_data  <= rx_sr;
                            rx_valid <= 1'b1;
                            state    <= last_q ? ST_HOLD : ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == 8'd0) begin
                        ss_n  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: three instances (CLK_DIV 4, 1, 255) sharing stimulus.
module tb_spi_master;

    logic       clk;
    logic       nRst;
    logic       en;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tv;
    logic       loop;
    logic       miso_val;
    logic [1:0] sel;

    logic       tx_valid_d4, tx_ready_d4, rx_valid_d4, busy_d4, sck_d4, ss_n_d4, mosi_d4, miso_d4;
    logic [7:0] rx_data_d4;
    logic       tx_valid_d1, tx_ready_d1, rx_valid_d1, busy_d1, sck_d1, ss_n_d1, mosi_d1, miso_d1;
    logic [7:0] rx_data_d1;
    logic       tx_valid_d255, tx_ready_d255, rx_valid_d255, busy_d255, sck_d255, ss_n_d255, mosi_d255, miso_d255;
    logic [7:0] rx_data_d255;

    logic       obs_tx_ready, obs_rx_valid, obs_busy, obs_sck, obs_ss_n, obs_mosi;
    logic [7:0] obs_rx_data;

    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];

    logic [7:0] slave_byte = 8'h5A;
    int         sl_idx = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign tx_valid_d4   = tv && (sel == 2'd0);
    assign tx_valid_d1   = tv && (sel == 2'd1);
    assign tx_valid_d255 = tv && (sel == 2'd2);
    assign miso_d4       = loop ? mosi_d4 : miso_val;
    assign miso_d1       = loop ? mosi_d1 : miso_val;

    // Mode-0 slave: presents its byte MSB first, advancing on each sck fall.
    always @(negedge sck_d255 or posedge ss_n_d255) begin
        if (ss_n_d255) sl_idx = 0;
        else           sl_idx = sl_idx + 1;
    end
    assign miso_d255 = (sl_idx < 8) ? slave_byte[7 - sl_idx] : 1'b0;

    spi_master #(.CLK_DIV(4)) u_d4 (
        .clk(clk), .nRst(nRst), .en(en), .tx_data(tx_data), .tx_valid(tx_valid_d4),
        .tx_last(tx_last), .tx_ready(tx_ready_d4), .rx_data(rx_data_d4), .rx_valid(rx_valid_d4),
        .busy(busy_d4), .sck(sck_d4), .ss_n(ss_n_d4), .mosi(mosi_d4), .miso(miso_d4)
    );

    spi_master #(.CLK_DIV(1)) u_d1 (
        .clk(clk), .nRst(nRst), .en(en), .tx_data(tx_data), .tx_valid(tx_valid_d1),
        .tx_last(tx_last), .tx_ready(tx_ready_d1), .rx_data(rx_data_d1), .rx_valid(rx_valid_d1),
        .busy(busy_d1), .sck(sck_d1), .ss_n(ss_n_d1), .mosi(mosi_d1), .miso(miso_d1)
    );

    spi_master #(.CLK_DIV(255)) u_d255 (
        .clk(clk), .nRst(nRst), .en(en), .tx_data(tx_data), .tx_valid(tx_valid_d255),
        .tx_last(tx_last), .tx_ready(tx_ready_d255), .rx_data(rx_data_d255), .rx_valid(rx_valid_d255),
        .busy(busy_d255), .sck(sck_d255), .ss_n(ss_n_d255), .mosi(mosi_d255), .miso(miso_d255)
    );

    always_comb begin
        obs_tx_ready = tx_ready_d4;
        obs_rx_data  = rx_data_d4;
        obs_rx_valid = rx_valid_d4;
        obs_busy     = busy_d4;
        obs_sck      = sck_d4;
        obs_ss_n     = ss_n_d4;
        obs_mosi     = mosi_d4;
        case (sel)
            2'd1: begin
                obs_tx_ready = tx_ready_d1;
                obs_rx_data  = rx_data_d1;
                obs_rx_valid = rx_valid_d1;
                obs_busy     = busy_d1;
                obs_sck      = sck_d1;
                obs_ss_n     = ss_n_d1;
                obs_mosi     = mosi_d1;
            end
            2'd2: begin
                obs_tx_ready = tx_ready_d255;
                obs_rx_data  = rx_data_d255;
                obs_rx_valid = rx_valid_d255;
                obs_busy     = busy_d255;
                obs_sck      = sck_d255;
                obs_ss_n     = ss_n_d255;
                obs_mosi     = mosi_d255;
            end
            default: ;
        endcase
    end

    // Drive one byte on the selected instance; acc is the cycle stamp of the accept edge, -1 on timeout.
    task automatic send_byte(input logic [7:0] d, input logic last, output int acc);
        acc = -1;
        tx_data = d;
        tx_last = last;
        for (int i = 0; i < 10000; i++) begin
            if (obs_tx_ready) begin
                tv = 1'b1;
                @(posedge clk); #1;
                acc = cyc;
                tv = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    // Wait for rx_valid, recording mosi at each sck rise; at = -1 on timeout.
    task automatic wait_rx(input int limit, output int at, output logic [7:0] mb, output int rises,
                           output int r1, output int r2, output logic ss_hi);
        logic prev;
        prev  = obs_sck;
        at    = -1;
        mb    = 8'd0;
        rises = 0;
        r1    = -1;
        r2    = -1;
        ss_hi = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            if (obs_sck && !prev) begin
                rises++;
                mb = {mb[6:0], obs_mosi};
                if (rises == 1) r1 = cyc;
                if (rises == 2) r2 = cyc;
            end
            prev = obs_sck;
            if (obs_ss_n) ss_hi = 1'b1;
            if (obs_rx_valid) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic check_rx(input string name);
        logic [7:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: rx_data=%h with no expected byte queued", name, obs_rx_data);
        end else begin
            e = exp_q.pop_front();
            if (obs_rx_data !== e) begin
                bad++;
                $display("FAIL %s: rx_data=%h expected %h", name, obs_rx_data, e);
            end
        end
    endtask

    task automatic test_reset();
        sel = 2'd0; tv = 1'b0; en = 1'b1; loop = 1'b0; miso_val = 1'b0;
        tx_data = 8'h00; tx_last = 1'b0; nRst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (sck_d4 !== 1'b0)     begin bad++; $display("FAIL rst_sck: got %b want 0", sck_d4); end
        total++; if (ss_n_d4 !== 1'b1)    begin bad++; $display("FAIL rst_ss_n: got %b want 1", ss_n_d4); end
        total++; if (mosi_d4 !== 1'b0)    begin bad++; $display("FAIL rst_mosi: got %b want 0", mosi_d4); end
        total++; if (rx_data_d4 !== 8'h00) begin bad++; $display("FAIL rst_rx_data: got %h want 00", rx_data_d4); end
        total++; if (rx_valid_d4 !== 1'b0) begin bad++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid_d4); end
        total++; if (busy_d4 !== 1'b0)    begin bad++; $display("FAIL rst_busy: got %b want 0", busy_d4); end
        nRst = 1'b1;
        @(posedge clk); #1;
        total++; if (tx_ready_d4 !== 1'b1) begin bad++; $display("FAIL idle_ready_en1: got %b want 1", tx_ready_d4); end
        en = 1'b0; #1;
        total++; if (tx_ready_d4 !== 1'b0) begin bad++; $display("FAIL idle_ready_en0: got %b want 0", tx_ready_d4); end
        en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_loopback_a5();
        int acc, at, rises, r1, r2;
        logic [7:0] mb;
        logic ss_hi;
        sel = 2'd0; loop = 1'b1;
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1, acc);
        wait_rx(200, at, mb, rises, r1, r2, ss_hi);
        total++; if (mb !== 8'hA5) begin bad++; $display("FAIL a5_mosi_bits: got %h want a5", mb); end
        check_rx("a5_rx_data");
        total++; if (at - acc !== 64) begin bad++; $display("FAIL a5_latency: got %0d want 64", at - acc); end
        total++; if (rises !== 8) begin bad++; $display("FAIL a5_sck_rises: got %0d want 8", rises); end
        total++; if (ss_hi !== 1'b0) begin bad++; $display("FAIL a5_ss_n_low: ss_n rose during byte"); end
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                total++; if (obs_rx_valid !== 1'b0) begin bad++; $display("FAIL a5_pulse_width: rx_valid=%b want 0", obs_rx_valid); end
            end
            if (k == 3) begin
                total++; if (obs_ss_n !== 1'b0) begin bad++; $display("FAIL a5_hold_ss_n: got %b want 0", obs_ss_n); end
            end
            if (k == 4) begin
                total++; if (obs_ss_n !== 1'b1) begin bad++; $display("FAIL a5_release_ss_n: got %b want 1", obs_ss_n); end
            end
        end
        loop = 1'b0;
    endtask

    task automatic test_multi_byte();
        int acc1, acc2, at1, at2, ra, rb, r1, r2;
        logic [7:0] mb;
        logic hi1, hi2;
        sel = 2'd1; loop = 1'b0; miso_val = 1'b1;
        exp_q.push_back(8'hFF);
        send_byte(8'h3C, 1'b0, acc1);
        wait_rx(100, at1, mb, ra, r1, r2, hi1);
        check_rx("multi_rx0");
        total++; if (mb !== 8'h3C) begin bad++; $display("FAIL multi_mosi0: got %h want 3c", mb); end
        total++; if (obs_ss_n !== 1'b0) begin bad++; $display("FAIL multi_gap_ss_n: got %b want 0", obs_ss_n); end
        exp_q.push_back(8'hFF);
        send_byte(8'hC3, 1'b1, acc2);
        wait_rx(100, at2, mb, rb, r1, r2, hi2);
        check_rx("multi_rx1");
        total++; if (mb !== 8'hC3) begin bad++; $display("FAIL multi_mosi1: got %h want c3", mb); end
        total++; if (at1 - acc1 !== 16) begin bad++; $display("FAIL multi_lat0: got %0d want 16", at1 - acc1); end
        total++; if (at2 - acc2 !== 16) begin bad++; $display("FAIL multi_lat1: got %0d want 16", at2 - acc2); end
        total++; if (ra + rb !== 16) begin bad++; $display("FAIL multi_sck_rises: got %0d want 16", ra + rb); end
        total++; if ((hi1 | hi2) !== 1'b0) begin bad++; $display("FAIL multi_ss_n_cont: ss_n rose inside frame"); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (obs_ss_n !== 1'b1) begin bad++; $display("FAIL multi_release: ss_n=%b want 1", obs_ss_n); end
        miso_val = 1'b0;
    endtask

    task automatic test_valid_held();
        int accepts, rxs, ready_busy;
        sel = 2'd0; loop = 1'b1;
        tx_data = 8'h96; tx_last = 1'b1;
        accepts = 0; rxs = 0; ready_busy = 0;
        tv = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (obs_tx_ready && tv) begin
                accepts++;
                exp_q.push_back(8'h96);
            end
            if (obs_busy && obs_tx_ready) ready_busy++;
            @(posedge clk); #1;
            if (accepts == 2) tv = 1'b0;
            if (obs_rx_valid) begin
                rxs++;
                check_rx("held_rx");
            end
            if (rxs == 2) break;
        end
        tv = 1'b0;
        total++; if (accepts !== 2) begin bad++; $display("FAIL held_accepts: got %0d want 2", accepts); end
        total++; if (rxs !== 2) begin bad++; $display("FAIL held_rx_count: got %0d want 2", rxs); end
        total++; if (ready_busy !== 0) begin bad++; $display("FAIL held_ready_busy: tx_ready high while busy %0d cycles", ready_busy); end
        repeat (6) @(posedge clk);
        #1;
        loop = 1'b0;
    endtask

    task automatic test_en_low();
        int acc, at, rises, r1, r2, ready_hi;
        logic [7:0] mb;
        logic ss_hi;
        sel = 2'd0; loop = 1'b1; en = 1'b1;
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b0, acc);
        en = 1'b0;
        wait_rx(200, at, mb, rises, r1, r2, ss_hi);
        check_rx("en_rx_81");
        total++; if (at - acc !== 64) begin bad++; $display("FAIL en_lat_81: got %0d want 64", at - acc); end
        tx_data = 8'h7E; tx_last = 1'b1; tv = 1'b1;
        ready_hi = 0; ss_hi = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (obs_tx_ready || obs_busy) ready_hi++;
            if (obs_ss_n) ss_hi = 1'b1;
        end
        total++; if (ready_hi !== 0) begin bad++; $display("FAIL en_no_accept: ready/busy seen %0d cycles want 0", ready_hi); end
        total++; if (ss_hi !== 1'b0) begin bad++; $display("FAIL en_suspend_ss_n: ss_n rose while suspended"); end
        en = 1'b1; #1;
        total++; if (obs_tx_ready !== 1'b1) begin bad++; $display("FAIL en_ready_back: got %b want 1", obs_tx_ready); end
        exp_q.push_back(8'h7E);
        @(posedge clk); #1;
        acc = cyc; tv = 1'b0;
        wait_rx(200, at, mb, rises, r1, r2, ss_hi);
        check_rx("en_rx_7e");
        total++; if (at - acc !== 64) begin bad++; $display("FAIL en_lat_cont: got %0d want 64", at - acc); end
        total++; if (mb !== 8'h7E) begin bad++; $display("FAIL en_mosi_7e: got %h want 7e", mb); end
        repeat (6) @(posedge clk);
        #1;
        loop = 1'b0;
    endtask

    task automatic test_reset_mid();
        int acc, rises, pulses;
        logic prev;
        sel = 2'd0; loop = 1'b1;
        send_byte(8'hF0, 1'b1, acc);
        rises = 0; prev = obs_sck;
        for (int i = 0; i < 100 && rises < 3; i++) begin
            @(posedge clk); #1;
            if (obs_sck && !prev) rises++;
            prev = obs_sck;
        end
        total++; if (rises !== 3) begin bad++; $display("FAIL rmid_reach: sck rises %0d want 3", rises); end
        #2 nRst = 1'b0;
        #1;
        total++; if (obs_ss_n !== 1'b1) begin bad++; $display("FAIL rmid_ss_n: got %b want 1", obs_ss_n); end
        total++; if (obs_sck !== 1'b0) begin bad++; $display("FAIL rmid_sck: got %b want 0", obs_sck); end
        total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", obs_busy); end
        total++; if (obs_rx_data !== 8'h00) begin bad++; $display("FAIL rmid_rx_data: got %h want 00", obs_rx_data); end
        repeat (2) @(posedge clk);
        #3 nRst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (obs_rx_valid) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL rmid_no_rx_valid: got %0d pulses want 0", pulses); end
        loop = 1'b0;
    endtask

    task automatic test_div255();
        int acc, at, rises, r1, r2;
        logic [7:0] mb;
        logic ss_hi;
        sel = 2'd2;
        exp_q.push_back(8'h5A);
        send_byte(8'h00, 1'b1, acc);
        wait_rx(5000, at, mb, rises, r1, r2, ss_hi);
        check_rx("d255_rx");
        total++; if (r2 - r1 !== 510) begin bad++; $display("FAIL d255_sck_period: got %0d want 510", r2 - r1); end
        total++; if (at - acc !== 4080) begin bad++; $display("FAIL d255_latency: got %0d want 4080", at - acc); end
        total++; if (rises !== 8) begin bad++; $display("FAIL d255_sck_rises: got %0d want 8", rises); end
    endtask

    initial begin
        test_reset();
        test_loopback_a5();
        test_multi_byte();
        test_valid_held();
        test_en_low();
        test_reset_mid();
        test_div255();
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_drain: %0d bytes never received", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
